// File: rtl/fp_convert_seq.sv
// fp_convert_seq: multi-cycle converter from a two's-complement sample to a
// small float {S, E, F}, value = F * 2^E. The sample is taken through ABS, then
// normalised one shift per cycle, then (optionally) rounded, and the result is
// held until the consumer takes it.
// Build option: define FPCVT_ROUND_EN for round-half-up with overflow and
// saturation handling. Without it the significand is truncated and the ROUND
// state does not exist.
module fp_convert_seq #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned EXP_W = 3,
    parameter int unsigned SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [SIG_W-1:0] out_f,
    output logic             busy
);

    localparam int unsigned MAG_W = IN_W - 1;

    localparam logic [EXP_W-1:0] E_STEP = 1;
`ifdef FPCVT_ROUND_EN
    localparam logic [EXP_W:0]   E_INC  = 1;
    localparam logic [SIG_W:0]   F_HALF = 1 << (SIG_W - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_NORM,
`ifdef FPCVT_ROUND_EN
        ST_ROUND,
`endif
        ST_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    data_q, data_d;
    logic               sign_q, sign_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               out_s_q, out_s_d;
    logic [EXP_W-1:0]   out_e_q, out_e_d;
    logic [SIG_W-1:0]   out_f_q, out_f_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [IN_W-1:0]    neg_data;
    logic [MAG_W-1:0]   mag_abs;
    logic               norm_done;
`ifdef FPCVT_ROUND_EN
    logic [SIG_W:0]     rnd_inc;
    logic [SIG_W:0]     f_round;
    logic [EXP_W:0]     e_round;
`endif

    // Datapath helpers: absolute value with saturation, normalise-done test, rounding.
    always_comb begin
        neg_data = '0 - data_q;
        if (data_q == {1'b1, {MAG_W{1'b0}}}) begin
            // The most negative sample has no positive counterpart: clamp it.
            mag_abs = '1;
        end else if (data_q[IN_W-1]) begin
            mag_abs = neg_data[MAG_W-1:0];
        end else begin
            mag_abs = data_q[MAG_W-1:0];
        end

        norm_done = mag_q[MAG_W-1] || (exp_q == '0);

`ifdef FPCVT_ROUND_EN
        rnd_inc    = '0;
        rnd_inc[0] = mag_q[MAG_W-1-SIG_W];
        f_round    = {1'b0, mag_q[MAG_W-1 -: SIG_W]} + rnd_inc;
        e_round    = {1'b0, exp_q};
        if (f_round[SIG_W]) begin
            // Carry out of the significand renormalises to the half point.
            f_round = F_HALF;
            e_round = e_round + E_INC;
        end
        if (e_round[EXP_W]) begin
            e_round = {1'b0, {EXP_W{1'b1}}};
            f_round = {1'b0, {SIG_W{1'b1}}};
        end
`endif
    end

    // Next-state and next-output computation for the conversion sequence.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        out_s_d   = out_s_q;
        out_e_d   = out_e_q;
        out_f_d   = out_f_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = ST_ABS;
                end
            end
            ST_ABS: begin
                sign_d  = data_q[IN_W-1];
                mag_d   = mag_abs;
                exp_d   = '1;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (norm_done) begin
`ifdef FPCVT_ROUND_EN
                    state_d = ST_ROUND;
`else
                    out_s_d = sign_q;
                    out_e_d = exp_q;
                    out_f_d = mag_q[MAG_W-1 -: SIG_W];
                    state_d = ST_OUT;
`endif
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - E_STEP;
                end
            end
`ifdef FPCVT_ROUND_EN
            ST_ROUND: begin
                out_s_d = sign_q;
                out_e_d = e_round[EXP_W-1:0];
                out_f_d = f_round[SIG_W-1:0];
                state_d = ST_OUT;
            end
`endif
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flags are derived from the next state so they are registered
        // alongside it and line up with the state they describe.
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign busy      = busy_q;

endmodule
